// File: rtl/dtc_tx_sched.sv
// dtc_tx_sched: front-end scheduler for the DTC transmitter.
// It holds one pending slot each for readout triggers, register-read replies and
// status requests. It grants one request at a time and pulses rdocmd/read/streq.
// It holds address/data/status stable for the whole frame.
module dtc_tx_sched #(
   parameter int unsigned MAX_CONSEC   = 4,
   parameter int unsigned RD_TIMEOUT   = 1023,
   parameter int unsigned START_TO     = 15,
   parameter logic [31:0] TIMEOUT_WORD = 32'hDEAD_DEAD
) (
   input  logic        dtc_clk,
   input  logic        rst_n,
   input  logic        trig,
   input  logic        rd_req,
   input  logic [31:0] rd_addr,
   input  logic        reg_vld,
   input  logic [31:0] reg_data,
   input  logic        st_req,
   input  logic [15:0] status_in,
   input  logic        tx_idle,
   output logic        rdocmd,
   output logic        read,
   output logic        streq,
   output logic [31:0] address,
   output logic [31:0] data,
   output logic        data_vld,
   output logic [15:0] status,
   output logic [7:0]  trig_drops,
   output logic [1:0]  err
);

   localparam int unsigned TMAX  = (RD_TIMEOUT > START_TO) ? RD_TIMEOUT : START_TO;
   localparam int unsigned CNT_W = $clog2(TMAX + 1);
   localparam int unsigned CON_W = $clog2(MAX_CONSEC + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT_START, S_WAIT_DATA, S_WAIT_DONE
   } state_e;

   typedef enum logic [1:0] {G_NONE, G_TRIG, G_RD, G_ST} gnt_e;

   state_e             state_q, state_d;
   gnt_e               gnt_q, gnt_d, gnt_sel;
   logic               p_trig_q, p_trig_d;
   logic               p_rd_q, p_rd_d;
   logic               p_st_q, p_st_d;
   logic [31:0]        addr_cap_q, addr_cap_d;
   logic [CON_W-1:0]   consec_q, consec_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        address_q, address_d;
   logic [31:0]        data_q, data_d;
   logic               data_vld_q, data_vld_d;
   logic [15:0]        status_q, status_d;
   logic [7:0]         drops_q, drops_d;
   logic [1:0]         err_q, err_d;

   // Next-state logic: arbitration, frame sequencing, timeouts and pending-slot bookkeeping.
   always_comb begin
      // NOTE: every signal gets a default here first, so no path can leave one unassigned and infer a latch.
      state_d    = state_q;
      gnt_d      = gnt_q;
      gnt_sel    = G_NONE;
      addr_cap_d = addr_cap_q;
      consec_d   = consec_q;
      cnt_d      = '0;
      address_d  = address_q;
      data_d     = data_q;
      data_vld_d = data_vld_q;
      status_d   = status_q;
      drops_d    = drops_q;
      err_d      = err_q;

      case (state_q)
         S_IDLE: begin
            if (tx_idle) begin
               // Anti-starvation: after MAX_CONSEC readouts, a waiting read/status goes first.
               if ((consec_q == CON_W'(MAX_CONSEC)) && (p_rd_q || p_st_q))
                  gnt_sel = p_rd_q ? G_RD : G_ST;
               else if (p_trig_q)
                  gnt_sel = G_TRIG;
               else if (p_rd_q)
                  gnt_sel = G_RD;
               else if (p_st_q)
                  gnt_sel = G_ST;
            end
            if (gnt_sel != G_NONE) begin
               state_d = S_ISSUE;
               gnt_d   = gnt_sel;
            end
            case (gnt_sel)
               G_TRIG: if (consec_q != CON_W'(MAX_CONSEC)) consec_d = consec_q + CON_W'(1);
               G_RD: begin
                  address_d = addr_cap_q;
                  consec_d  = '0;
               end
               G_ST: begin
                  status_d = status_in;
                  consec_d = '0;
               end
               default: ;
            endcase
         end
         S_ISSUE: state_d = S_WAIT_START;
         S_WAIT_START: begin
            if (!tx_idle)
               state_d = (gnt_q == G_RD) ? S_WAIT_DATA : S_WAIT_DONE;
            else if (cnt_q == CNT_W'(START_TO - 1)) begin
               err_d[1] = 1'b1;
               state_d  = S_IDLE;
            end else
               cnt_d = cnt_q + CNT_W'(1);
         end
         S_WAIT_DATA: begin
            if (reg_vld) begin
               data_d     = reg_data;
               data_vld_d = 1'b1;
               state_d    = S_WAIT_DONE;
            end else if (cnt_q == CNT_W'(RD_TIMEOUT - 1)) begin
               data_d     = TIMEOUT_WORD;
               data_vld_d = 1'b1;
               err_d[0]   = 1'b1;
               state_d    = S_WAIT_DONE;
            end else
               cnt_d = cnt_q + CNT_W'(1);
         end
         S_WAIT_DONE: begin
            if (tx_idle) begin
               data_vld_d = 1'b0;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A slot is busy if it stays pending past this cycle. A pulse in the grant cycle re-arms the slot.
      p_trig_d = (p_trig_q && (gnt_sel != G_TRIG)) || trig;
      p_rd_d   = (p_rd_q && (gnt_sel != G_RD)) || rd_req;
      p_st_d   = (p_st_q && (gnt_sel != G_ST)) || st_req;

      if (trig && p_trig_q && (gnt_sel != G_TRIG) && (drops_q != 8'hFF))
         drops_d = drops_q + 8'd1;

      if (rd_req && !(p_rd_q && (gnt_sel != G_RD)))
         addr_cap_d = rd_addr;
   end

   // State register. Every flop resets asynchronously, so a mid-frame reset clears the outputs at once.
   always_ff @(posedge dtc_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         gnt_q      <= G_NONE;
         p_trig_q   <= 1'b0;
         p_rd_q     <= 1'b0;
         p_st_q     <= 1'b0;
         addr_cap_q <= '0;
         consec_q   <= '0;
         cnt_q      <= '0;
         address_q  <= '0;
         data_q     <= '0;
         data_vld_q <= 1'b0;
         status_q   <= '0;
         drops_q    <= '0;
         err_q      <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         p_trig_q   <= p_trig_d;
         p_rd_q     <= p_rd_d;
         p_st_q     <= p_st_d;
         addr_cap_q <= addr_cap_d;
         consec_q   <= consec_d;
         cnt_q      <= cnt_d;
         address_q  <= address_d;
         data_q     <= data_d;
         data_vld_q <= data_vld_d;
         status_q   <= status_d;
         drops_q    <= drops_d;
         err_q      <= err_d;
      end
   end

   // The command pulse for the granted type is decoded from the one-cycle ISSUE state.
   assign rdocmd     = (state_q == S_ISSUE) && (gnt_q == G_TRIG);
   assign read       = (state_q == S_ISSUE) && (gnt_q == G_RD);
   assign streq      = (state_q == S_ISSUE) && (gnt_q == G_ST);
   assign address    = address_q;
   assign data       = data_q;
   assign data_vld   = data_vld_q;
   assign status     = status_q;
   assign trig_drops = drops_q;
   assign err        = err_q;

endmodule

// File: tb/tb_dtc_tx_sched.sv
// Directed bench for dtc_tx_sched. It plays a simple transmitter by driving tx_idle.
// All expected values are computed by hand from the scheduler's timing.
module tb_dtc_tx_sched;

   logic        dtc_clk = 1'b0;
   logic        rst_n;
   logic        trig, rd_req, reg_vld, st_req, tx_idle;
   logic [31:0] rd_addr, reg_data;
   logic [15:0] status_in;
   logic        rdocmd, read, streq, data_vld;
   logic [31:0] address, data;
   logic [15:0] status;
   logic [7:0]  trig_drops;
   logic [1:0]  err;

   int checks   = 0;
   int failures = 0;
   int kind;
   int seen;
   int exp_order [7] = '{1, 1, 1, 1, 2, 1, 3};

   dtc_tx_sched dut (
      .dtc_clk   (dtc_clk),
      .rst_n     (rst_n),
      .trig      (trig),
      .rd_req    (rd_req),
      .rd_addr   (rd_addr),
      .reg_vld   (reg_vld),
      .reg_data  (reg_data),
      .st_req    (st_req),
      .status_in (status_in),
      .tx_idle   (tx_idle),
      .rdocmd    (rdocmd),
      .read      (read),
      .streq     (streq),
      .address   (address),
      .data      (data),
      .data_vld  (data_vld),
      .status    (status),
      .trig_drops(trig_drops),
      .err       (err)
   );

   always #5 dtc_clk = ~dtc_clk;

   // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge dtc_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Bounded wait for the next command pulse: 1=rdocmd, 2=read, 3=streq, 0=none within budget.
   task automatic wait_pulse(output int k);
      int n;
      n = 0;
      while (!(rdocmd || read || streq) && n < 200) begin
         tick();
         n++;
      end
      if (rdocmd)     k = 1;
      else if (read)  k = 2;
      else if (streq) k = 3;
      else            k = 0;
   endtask

   initial begin
      rst_n = 1'b0; trig = 1'b0; rd_req = 1'b0; reg_vld = 1'b0; st_req = 1'b0;
      tx_idle = 1'b1; rd_addr = '0; reg_data = '0; status_in = '0;
      tick(); tick();

      // Reset state
      check("rst_cmds", {29'd0, rdocmd, read, streq}, 32'd0);
      check("rst_addr", address, 32'd0);
      check("rst_data", {31'd0, data_vld} | data, 32'd0);
      check("rst_misc", {6'd0, status, trig_drops, err}, 32'd0);
      rst_n = 1'b1;
      tick();

      // 1: single readout, rdocmd two cycles after trig, then a 200-cycle frame
      trig = 1'b1; tick(); trig = 1'b0;
      check("t1_rdocmd_early", rdocmd, 1'b0);
      tick();
      check("t1_rdocmd_pulse", rdocmd, 1'b1);
      tick();
      check("t1_rdocmd_once", rdocmd, 1'b0);
      tick(); tick();
      tx_idle = 1'b0;
      repeat (200) tick();
      tx_idle = 1'b1;
      tick();
      check("t1_drops", trig_drops, 8'd0);

      // 2: register read reply; rd_addr is sampled with rd_req, data arrives 10 cycles after read
      rd_addr = 32'h0000_0104; rd_req = 1'b1; tick();
      rd_req = 1'b0; rd_addr = 32'hFFFF_FFFF;
      tick();
      check("t2_read_pulse", read, 1'b1);
      check("t2_address", address, 32'h0000_0104);
      tick();
      tx_idle = 1'b0;
      repeat (8) tick();
      check("t2_vld_before", data_vld, 1'b0);
      reg_vld = 1'b1; reg_data = 32'h1234_5678; tick();
      reg_vld = 1'b0; reg_data = 32'h0;
      check("t2_data", data, 32'h1234_5678);
      check("t2_vld", data_vld, 1'b1);
      repeat (20) tick();
      check("t2_vld_held", data_vld, 1'b1);
      tx_idle = 1'b1; tick();
      check("t2_vld_clear", data_vld, 1'b0);
      reg_vld = 1'b1; reg_data = 32'h5555_AAAA; tick();
      reg_vld = 1'b0;
      check("t2_stray_vld_ignored", data, 32'h1234_5678);

      // 3: all three requests at once, trig re-pulsed after the first four readouts
      trig = 1'b1; rd_req = 1'b1; st_req = 1'b1; rd_addr = 32'h0000_0200; status_in = 16'hBEEF;
      tick();
      trig = 1'b0; rd_req = 1'b0; st_req = 1'b0; rd_addr = 32'h0;
      for (int i = 0; i < 7; i++) begin
         wait_pulse(kind);
         check($sformatf("t3_grant%0d", i), kind, exp_order[i]);
         if (kind == 2) check("t3_address", address, 32'h0000_0200);
         if (kind == 3) check("t3_status", status, 16'hBEEF);
         trig = (kind == 1) && (i < 4);
         tick();
         trig = 1'b0; tx_idle = 1'b0;
         tick();
         if (kind == 2) begin
            reg_vld = 1'b1; reg_data = 32'hCAFE_0001; tick(); reg_vld = 1'b0;
         end
         tx_idle = 1'b1;
         tick();
      end
      status_in = 16'h1111;
      tick();
      check("t3_status_held", status, 16'hBEEF);
      check("t3_drops", trig_drops, 8'd0);

      // 4: register read that never returns data
      rd_addr = 32'h0000_0300; rd_req = 1'b1; tick(); rd_req = 1'b0;
      wait_pulse(kind);
      check("t4_read", kind, 2);
      tick();
      tx_idle = 1'b0;
      tick();
      repeat (1022) tick();
      check("t4_vld_before_to", data_vld, 1'b0);
      check("t4_err_before_to", err, 2'b00);
      tick();
      check("t4_vld", data_vld, 1'b1);
      check("t4_data", data, 32'hDEAD_DEAD);
      check("t4_err", err, 2'b01);
      tx_idle = 1'b1; tick();

      // 5: 300 triggers during one long readout
      trig = 1'b1; tick(); trig = 1'b0;
      wait_pulse(kind);
      check("t5_first", kind, 1);
      tick();
      tx_idle = 1'b0;
      for (int i = 0; i < 300; i++) begin
         trig = 1'b1; tick(); trig = 1'b0; tick();
      end
      check("t5_drops", trig_drops, 8'd255);
      tx_idle = 1'b1; tick();
      wait_pulse(kind);
      check("t5_extra", kind, 1);
      tick(); tx_idle = 1'b0; tick(); tx_idle = 1'b1; tick();
      seen = 0;
      for (int i = 0; i < 50; i++) begin
         if (rdocmd || read || streq) seen++;
         tick();
      end
      check("t5_no_more", seen, 0);
      check("t5_drops_sat", trig_drops, 8'd255);

      // 6a: transmitter never leaves idle after a status command
      status_in = 16'h5A5A; st_req = 1'b1; tick(); st_req = 1'b0;
      wait_pulse(kind);
      check("t6_streq", kind, 3);
      check("t6_status", status, 16'h5A5A);
      repeat (15) tick();
      check("t6_err_before_to", err[1], 1'b0);
      tick();
      check("t6_err", err, 2'b11);
      rd_addr = 32'h0000_0400; rd_req = 1'b1; tick(); rd_req = 1'b0;
      tick();
      check("t6_idle_regrant", {29'd0, rdocmd, read, streq}, 32'd2);

      // 6b: reset asserted while waiting for register data
      tick(); tx_idle = 1'b0; tick(); tick(); tick();
      rst_n = 1'b0;
      #2;
      check("t6_rst_cmds", {28'd0, rdocmd, read, streq, data_vld}, 32'd0);
      check("t6_rst_addr", address, 32'd0);
      check("t6_rst_misc", {6'd0, status, trig_drops, err}, 32'd0);
      tick();
      rst_n = 1'b1; tx_idle = 1'b1;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (rdocmd || read || streq) seen++;
         tick();
      end
      check("t6_pending_lost", seen, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
